// File: rtl/c3aibadapt_avmm_nrw_pkg.sv
// Shared types and helpers for the USR AVMM 32-to-8 narrowing bridge.
package c3aibadapt_avmm_nrw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_WAIT_WR = 3'd3,
    ST_DONE    = 3'd4
  } nrw_state_e;

  localparam int LANES           = 4;
  localparam int LANE_W          = 8;
  localparam int DEF_TIMEOUT_CYC = 255;

  function automatic logic [LANE_W-1:0] lane_byte(input logic [LANES*LANE_W-1:0] d,
                                                  input logic [1:0] k);
    case (k)
      2'd0:    return d[7:0];
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      default: return d[31:24];
    endcase
  endfunction

  function automatic logic [LANES*LANE_W-1:0] lane_merge(input logic [LANES*LANE_W-1:0] d,
                                                         input logic [1:0] k,
                                                         input logic [LANE_W-1:0] b);
    logic [LANES*LANE_W-1:0] r;
    r = d;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [LANES-1:0] lane_bit(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

endpackage

// File: rtl/c3aibadapt_avmm_lane_sel.sv
// Lowest-set-bit encoder over the pending byte-lane mask.
module c3aibadapt_avmm_lane_sel
  import c3aibadapt_avmm_nrw_pkg::*;
(
  input  logic [LANES-1:0] mask,
  output logic [1:0]       idx,
  output logic             any_set
);

  // lowest pending lane wins so bytes always go out in ascending order
  always_comb begin
    any_set = |mask;
    if (mask[0])      idx = 2'd0;
    else if (mask[1]) idx = 2'd1;
    else if (mask[2]) idx = 2'd2;
    else if (mask[3]) idx = 2'd3;
    else              idx = 2'd0;
  end

endmodule

// File: rtl/c3aibadapt_avmm_usr32_nrw.sv
// Dword-to-byte AVMM narrowing bridge: one byte transaction per enabled lane.
// Optional response timeout enabled by defining C3AIBADAPT_AVMM_NRW_TIMEOUT_EN.
module c3aibadapt_avmm_usr32_nrw
  import c3aibadapt_avmm_nrw_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              i_usr_avmm_clk,
  input  logic              i_usr_avmm_rst,
  input  logic              i_usr_avmm32_read,
  input  logic              i_usr_avmm32_write,
  input  logic [ADDR_W-3:0] i_usr_avmm32_addr,
  input  logic [31:0]       i_usr_avmm32_wdata,
  input  logic [3:0]        i_usr_avmm32_byte_en,
  output logic [31:0]       o_usr_avmm32_rdata,
  output logic              o_usr_avmm32_rdatavalid,
  output logic              o_usr_avmm32_waitrequest,
  output logic              o_usr_avmm_read,
  output logic              o_usr_avmm_write,
  output logic [ADDR_W-1:0] o_usr_avmm_addr,
  output logic [7:0]        o_usr_avmm_wdata,
  input  logic [7:0]        i_usr_avmm_rdata,
  input  logic              i_usr_avmm_readdatavalid,
  input  logic              i_usr_avmm_writedone,
  input  logic              i_usr_avmm_waitrequest,
  output logic              o_usr_avmm32_timeout
);

  nrw_state_e        state_r;
  logic [ADDR_W-3:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdbuf_r;
  logic [3:0]        mask_r;
  logic              is_read_r;
  logic [1:0]        k_r;
  logic              rst_dly_r;

  logic              accept_s;
  logic              tmo_hit_s;
  logic              rd_resp_s;
  logic              wr_resp_s;
  logic [7:0]        resp_byte_s;
  logic [3:0]        mask_nxt_s;
  logic [ADDR_W-3:0] addr_src_s;
  logic [31:0]       wdata_src_s;
  logic [1:0]        k_nxt_s;
  logic              any_nxt_s;

`ifdef C3AIBADAPT_AVMM_NRW_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             waiting_s;
  logic             real_resp_s;

  assign waiting_s   = (state_r == ST_WAIT_RD) || (state_r == ST_WAIT_WR);
  assign real_resp_s = ((state_r == ST_WAIT_RD) && i_usr_avmm_readdatavalid) ||
                       ((state_r == ST_WAIT_WR) && i_usr_avmm_writedone);
  assign tmo_hit_s   = waiting_s && !real_resp_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

  // wait-cycle counter, restarted for every lane issued
  always_ff @(posedge i_usr_avmm_clk or posedge i_usr_avmm_rst) begin
    if (i_usr_avmm_rst)  tmo_cnt_r <= '0;
    else if (waiting_s)  tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    else                 tmo_cnt_r <= '0;
  end

  // sticky flag: only reset clears it
  always_ff @(posedge i_usr_avmm_clk or posedge i_usr_avmm_rst) begin
    if (i_usr_avmm_rst)  o_usr_avmm32_timeout <= 1'b0;
    else if (tmo_hit_s)  o_usr_avmm32_timeout <= 1'b1;
  end
`else
  assign tmo_hit_s            = 1'b0;
  assign o_usr_avmm32_timeout = 1'b0;
`endif

  // next-lane selection: from the incoming command in IDLE, else from what remains
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && !o_usr_avmm32_waitrequest &&
                (i_usr_avmm32_read || i_usr_avmm32_write);
    rd_resp_s = (state_r == ST_WAIT_RD) && (i_usr_avmm_readdatavalid || tmo_hit_s);
    wr_resp_s = (state_r == ST_WAIT_WR) && (i_usr_avmm_writedone || tmo_hit_s);
    resp_byte_s = tmo_hit_s ? 8'hFF : i_usr_avmm_rdata;
    if (state_r == ST_IDLE) begin
      mask_nxt_s  = i_usr_avmm32_byte_en;
      addr_src_s  = i_usr_avmm32_addr;
      wdata_src_s = i_usr_avmm32_wdata;
    end else begin
      mask_nxt_s  = mask_r & ~lane_bit(k_r);
      addr_src_s  = addr_r;
      wdata_src_s = wdata_r;
    end
  end

  c3aibadapt_avmm_lane_sel u_lane_sel (
    .mask    (mask_nxt_s),
    .idx     (k_nxt_s),
    .any_set (any_nxt_s)
  );

  // main sequencer; all outputs are registered here
  always_ff @(posedge i_usr_avmm_clk or posedge i_usr_avmm_rst) begin
    if (i_usr_avmm_rst) begin
      state_r                  <= ST_IDLE;
      addr_r                   <= '0;
      wdata_r                  <= 32'h0000_0000;
      rdbuf_r                  <= 32'h0000_0000;
      mask_r                   <= 4'b0000;
      is_read_r                <= 1'b0;
      k_r                      <= 2'd0;
      rst_dly_r                <= 1'b1;
      o_usr_avmm32_rdata       <= 32'h0000_0000;
      o_usr_avmm32_rdatavalid  <= 1'b0;
      o_usr_avmm32_waitrequest <= 1'b1;
      o_usr_avmm_read          <= 1'b0;
      o_usr_avmm_write         <= 1'b0;
      o_usr_avmm_addr          <= '0;
      o_usr_avmm_wdata         <= 8'h00;
    end else begin
      rst_dly_r               <= 1'b0;
      o_usr_avmm32_rdatavalid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r    <= i_usr_avmm32_addr;
            wdata_r   <= i_usr_avmm32_wdata;
            mask_r    <= i_usr_avmm32_byte_en;
            rdbuf_r   <= 32'h0000_0000;
            is_read_r <= i_usr_avmm32_read;
            if (!any_nxt_s) begin
              state_r                  <= i_usr_avmm32_read ? ST_DONE : ST_IDLE;
              o_usr_avmm32_waitrequest <= i_usr_avmm32_read;
            end else begin
              state_r                  <= ST_ISSUE;
              k_r                      <= k_nxt_s;
              o_usr_avmm_addr          <= {addr_src_s, k_nxt_s};
              o_usr_avmm_wdata         <= lane_byte(wdata_src_s, k_nxt_s);
              o_usr_avmm_read          <= i_usr_avmm32_read;
              o_usr_avmm_write         <= !i_usr_avmm32_read;
              o_usr_avmm32_waitrequest <= 1'b1;
            end
          end else begin
            o_usr_avmm32_waitrequest <= rst_dly_r;
          end
        end
        ST_ISSUE: begin
          if (!i_usr_avmm_waitrequest) begin
            o_usr_avmm_read  <= 1'b0;
            o_usr_avmm_write <= 1'b0;
            state_r          <= is_read_r ? ST_WAIT_RD : ST_WAIT_WR;
          end
        end
        ST_WAIT_RD, ST_WAIT_WR: begin
          if (rd_resp_s || wr_resp_s) begin
            mask_r <= mask_nxt_s;
            if (rd_resp_s) rdbuf_r <= lane_merge(rdbuf_r, k_r, resp_byte_s);
            if (!any_nxt_s) begin
              state_r                  <= is_read_r ? ST_DONE : ST_IDLE;
              o_usr_avmm32_waitrequest <= is_read_r;
            end else begin
              state_r          <= ST_ISSUE;
              k_r              <= k_nxt_s;
              o_usr_avmm_addr  <= {addr_src_s, k_nxt_s};
              o_usr_avmm_wdata <= lane_byte(wdata_src_s, k_nxt_s);
              o_usr_avmm_read  <= is_read_r;
              o_usr_avmm_write <= !is_read_r;
            end
          end
        end
        ST_DONE: begin
          o_usr_avmm32_rdata       <= rdbuf_r;
          o_usr_avmm32_rdatavalid  <= 1'b1;
          o_usr_avmm32_waitrequest <= 1'b0;
          state_r                  <= ST_IDLE;
        end
        default: begin
          state_r                  <= ST_IDLE;
          o_usr_avmm_read          <= 1'b0;
          o_usr_avmm_write         <= 1'b0;
          o_usr_avmm32_waitrequest <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c3aibadapt_avmm_usr32_nrw.sv
// Directed bench for the narrowing bridge with a byte-wide responder and scoreboard.
module tb_c3aibadapt_avmm_usr32_nrw;
  localparam int ADDR_W = 19;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              up_rd = 1'b0, up_wr = 1'b0;
  logic [ADDR_W-3:0] up_addr = '0;
  logic [31:0]       up_wdata = 32'h0;
  logic [3:0]        up_be = 4'h0;
  logic [31:0]       up_rdata;
  logic              up_rdv, up_wait, up_tmo;
  logic              ds_rd, ds_wr;
  logic [ADDR_W-1:0] ds_addr;
  logic [7:0]        ds_wdata;
  logic [7:0]        ds_rdata = 8'h0;
  logic              ds_rdv = 1'b0, ds_wd = 1'b0, ds_wait = 1'b0;

  c3aibadapt_avmm_usr32_nrw #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(8)) dut (
    .i_usr_avmm_clk(clk), .i_usr_avmm_rst(rst),
    .i_usr_avmm32_read(up_rd), .i_usr_avmm32_write(up_wr),
    .i_usr_avmm32_addr(up_addr), .i_usr_avmm32_wdata(up_wdata),
    .i_usr_avmm32_byte_en(up_be), .o_usr_avmm32_rdata(up_rdata),
    .o_usr_avmm32_rdatavalid(up_rdv), .o_usr_avmm32_waitrequest(up_wait),
    .o_usr_avmm_read(ds_rd), .o_usr_avmm_write(ds_wr), .o_usr_avmm_addr(ds_addr),
    .o_usr_avmm_wdata(ds_wdata), .i_usr_avmm_rdata(ds_rdata),
    .i_usr_avmm_readdatavalid(ds_rdv), .i_usr_avmm_writedone(ds_wd),
    .i_usr_avmm_waitrequest(ds_wait), .o_usr_avmm32_timeout(up_tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ds_t;

  ds_t         ds_exp_q[$];
  logic [31:0] rd_exp_q[$];
  int checks = 0, failures = 0;
  int ds_count = 0, ds_stall = 0, ds_stall_lane = 0, ds_drop_lane = -1, stall_hold = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane_val(input logic [1:0] k);
    case (k)
      2'd0:    return 8'hAA;
      2'd1:    return 8'hBB;
      2'd2:    return 8'hCC;
      default: return 8'hDD;
    endcase
  endfunction

  // byte responder: optional stall, answer on the cycle after acceptance
  initial begin : responder
    bit                rsp_pend = 1'b0, rsp_rd = 1'b0;
    logic [7:0]        rsp_data = 8'h0;
    int                hold_cnt = 0;
    logic [ADDR_W-1:0] h_addr = '0;
    logic [7:0]        h_wdata = 8'h0;
    logic              h_wr = 1'b0;
    ds_t               e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ds_wait = 1'b0; ds_rdv = 1'b0; ds_wd = 1'b0; rsp_pend = 1'b0; hold_cnt = 0;
      end else begin
        ds_rdv   = rsp_pend && rsp_rd;
        ds_wd    = rsp_pend && !rsp_rd;
        ds_rdata = rsp_pend ? rsp_data : 8'h00;
        rsp_pend = 1'b0;
        if (ds_rd || ds_wr) begin
          chk("ds_one_cmd", 64'(ds_rd & ds_wr), 64'd0);
          chk("up_wait_busy", 64'(up_wait), 64'd1);
          if (hold_cnt == 0) begin
            h_addr = ds_addr; h_wdata = ds_wdata; h_wr = ds_wr;
          end else begin
            chk("ds_hold_addr", 64'(ds_addr), 64'(h_addr));
            chk("ds_hold_wdata", 64'(ds_wdata), 64'(h_wdata));
            chk("ds_hold_wr", 64'(ds_wr), 64'(h_wr));
          end
          hold_cnt++;
          if (hold_cnt <= ds_stall && int'(ds_addr[1:0]) == ds_stall_lane) begin
            ds_wait = 1'b1;
          end else begin
            ds_wait = 1'b0;
            ds_count++;
            if (int'(ds_addr[1:0]) == ds_stall_lane) stall_hold = hold_cnt;
            chk("ds_expected_pending", 64'(ds_exp_q.size() != 0), 64'd1);
            if (ds_exp_q.size() != 0) begin
              e = ds_exp_q.pop_front();
              chk("ds_rw", 64'(ds_wr), 64'(e.wr));
              chk("ds_addr", 64'(ds_addr), 64'(e.addr));
              if (e.wr) chk("ds_wdata", 64'(ds_wdata), 64'(e.data));
            end
            rsp_pend = !(ds_rd && int'(ds_addr[1:0]) == ds_drop_lane);
            rsp_rd   = ds_rd;
            rsp_data = lane_val(ds_addr[1:0]);
            hold_cnt = 0;
          end
        end else begin
          ds_wait = 1'b0;
        end
      end
    end
  end

  task automatic up_read(input logic [ADDR_W-3:0] a, input logic [3:0] be,
                         input bit also_wr, input int exp_lat);
    logic [31:0] exp = 32'h0;
    int cyc = 0;
    bit got = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) begin
        ds_exp_q.push_back('{1'b0, {a, 2'(l)}, 8'h00});
        exp[l*8 +: 8] = (l == ds_drop_lane) ? 8'hFF : lane_val(2'(l));
      end
    end
    rd_exp_q.push_back(exp);
    @(negedge clk);
    chk("up_ready", 64'(up_wait), 64'd0);
    up_rd = 1'b1; up_wr = also_wr; up_addr = a; up_be = be; up_wdata = $urandom;
    @(posedge clk); #1 up_rd = 1'b0; up_wr = 1'b0;
    while (!got && cyc < 300) begin
      @(posedge clk); #1 cyc++;
      if (up_rdv) got = 1'b1;
    end
    chk("rd_valid_seen", 64'(got), 64'd1);
    if (got) begin
      chk("rd_data", 64'(up_rdata), 64'(rd_exp_q.pop_front()));
      if (exp_lat >= 0) chk("rd_latency", 64'(cyc), 64'(exp_lat));
      @(posedge clk); #1;
      chk("rd_valid_pulse", 64'(up_rdv), 64'd0);
      chk("rd_data_hold", 64'(up_rdata), 64'(exp));
    end
    chk("ds_all_issued", 64'(ds_exp_q.size()), 64'd0);
  endtask

  task automatic up_write(input logic [ADDR_W-3:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int exp_lat);
    int cyc = 0;
    for (int l = 0; l < 4; l++)
      if (be[l]) ds_exp_q.push_back('{1'b1, {a, 2'(l)}, wd[l*8 +: 8]});
    @(negedge clk);
    chk("up_ready", 64'(up_wait), 64'd0);
    up_wr = 1'b1; up_addr = a; up_be = be; up_wdata = wd;
    @(posedge clk); #1 up_wr = 1'b0;
    while (up_wait && cyc < 300) begin
      @(posedge clk); #1 cyc++;
    end
    chk("wr_latency", 64'(cyc), 64'(exp_lat));
    chk("ds_all_issued", 64'(ds_exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", 64'(up_wait), 64'd1);
    chk("rst_outs", 64'({ds_rd, ds_wr, up_rdv, up_tmo}), 64'd0);
    chk("rst_rdata", 64'(up_rdata), 64'd0);
    chk("rst_ds_addr", 64'({ds_addr, ds_wdata}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1 chk("rel_wait_first", 64'(up_wait), 64'd1);
    @(posedge clk); #1 chk("rel_wait_second", 64'(up_wait), 64'd0);

    up_read(17'h00010, 4'hF, 1'b0, 9);
    chk("full_read_data", 64'(up_rdata), 64'h0000_0000_DDCC_BBAA);

    n0 = ds_count;
    up_write(17'h00021, 32'h1122_3344, 4'b1010, 4);
    chk("sparse_write_count", 64'(ds_count - n0), 64'd2);

    n0 = ds_count;
    up_read(17'h00055, 4'h0, 1'b0, 1);
    chk("zero_be_no_traffic", 64'(ds_count - n0), 64'd0);

    n0 = ds_count;
    up_write(17'h00033, 32'h0, 4'h0, 0);
    chk("zero_be_wr_no_traffic", 64'(ds_count - n0), 64'd0);

    ds_stall = 3; ds_stall_lane = 0;
    up_write(17'h00040, 32'hA5A5_C35A, 4'b0011, 7);
    chk("stall_hold_cycles", 64'(stall_hold), 64'd4);
    ds_stall = 0;

    up_read(17'h00101, 4'b0101, 1'b0, 5);
    up_read(17'h1FFFF, 4'b1000, 1'b0, 3);
    up_read(17'h00077, 4'b0110, 1'b1, 5);
    up_write(17'h00002, 32'hDEAD_BEEF, 4'b1111, 8);

    // reset in the middle of a 4-lane read
    for (int l = 0; l < 4; l++) ds_exp_q.push_back('{1'b0, {17'h00ABC, 2'(l)}, 8'h00});
    @(negedge clk);
    up_rd = 1'b1; up_addr = 17'h00ABC; up_be = 4'hF;
    @(posedge clk); #1 up_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_wait", 64'(up_wait), 64'd1);
    chk("midrst_outs", 64'({ds_rd, ds_wr, up_rdv}), 64'd0);
    chk("midrst_rdata", 64'(up_rdata), 64'd0);
    ds_exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 chk("midrst_rel_wait1", 64'(up_wait), 64'd1);
    @(posedge clk); #1 chk("midrst_rel_wait0", 64'(up_wait), 64'd0);
    up_read(17'h00200, 4'b1001, 1'b0, 5);

`ifdef C3AIBADAPT_AVMM_NRW_TIMEOUT_EN
    ds_drop_lane = 1;
    up_read(17'h00123, 4'hF, 1'b0, -1);
    chk("tmo_rdata", 64'(up_rdata), 64'h0000_0000_DDCC_FFAA);
    chk("tmo_flag_set", 64'(up_tmo), 64'd1);
    ds_drop_lane = -1;
    up_read(17'h00124, 4'b0011, 1'b0, 5);
    chk("tmo_flag_sticky", 64'(up_tmo), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("tmo_flag_rst", 64'(up_tmo), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
`else
    chk("tmo_tied0", 64'(up_tmo), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
